// File: rtl/cv_mem_mapper.sv
// cv_mem_mapper
//   Memory mapper for the ColecoVision/ADAM core. The 64K Z80 space is split
//   into 2**WIN_BITS equal windows. Each access resolves to a source (BIOS,
//   main RAM, cart, expansion RAM/ROM, EOS, writer) and a page from registered
//   mapping state. That state is updated by the ADAM memory-mode port, the SGM
//   port, MegaCart hotspot reads and a two-port per-window override interface.
//
// Ports
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   adam_i, sg1000_i          static machine-mode straps
//   a_i, d_i                  Z80 address / write data
//   mreq_n_i .. rfsh_n_i      Z80 bus strobes
//   cart_pages_i              cart size mask (pages-1)
//   src_o                     source of current access (0 = none)
//   sel_n_o                   active-low one-hot select indexed by src_o
//   page_o                    page for the current access
//   map_chg_o                 one-cycle pulse after a mapping register update
//   ready_o                   high once the default map is loaded
module cv_mem_mapper #(
  parameter int unsigned WIN_BITS  = 3,
  parameter int unsigned PAGE_W    = 6,
  parameter logic [7:0]  MODE_PORT = 8'h7F,
  parameter logic [7:0]  SGM_PORT  = 8'h53,
  parameter logic [7:0]  BANK_PORT = 8'h60
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              adam_i,
  input  logic              sg1000_i,
  input  logic [15:0]       a_i,
  input  logic [7:0]        d_i,
  input  logic              mreq_n_i,
  input  logic              iorq_n_i,
  input  logic              rd_n_i,
  input  logic              wr_n_i,
  input  logic              rfsh_n_i,
  input  logic [PAGE_W-1:0] cart_pages_i,
  output logic [2:0]        src_o,
  output logic [7:0]        sel_n_o,
  output logic [PAGE_W-1:0] page_o,
  output logic              map_chg_o,
  output logic              ready_o
);

  localparam int unsigned NWIN      = 1 << WIN_BITS;
  localparam logic [7:0]  BANK_DATA = BANK_PORT + 8'd1;

  localparam logic [2:0] SRC_NONE   = 3'd0;
  localparam logic [2:0] SRC_BIOS   = 3'd1;
  localparam logic [2:0] SRC_RAM    = 3'd2;
  localparam logic [2:0] SRC_CART   = 3'd3;
  localparam logic [2:0] SRC_EXPRAM = 3'd4;
  localparam logic [2:0] SRC_EXPROM = 3'd5;
  localparam logic [2:0] SRC_WRITER = 3'd7;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state, state_nxt;
  logic [1:0]          lower_mode, upper_mode;
  logic [PAGE_W-1:0]   megacart_page;
  logic                sgm_en;
  logic [WIN_BITS-1:0] bank_idx;
  logic [NWIN-1:0]     ovr_en;
  logic [2:0]          ovr_src  [NWIN];
  logic [PAGE_W-1:0]   ovr_page [NWIN];
  logic                map_chg;

  logic                io_wr, io_wr_q, hot_rd, hot_rd_q;
  logic                io_evt, hot_evt, megacart;
  logic [PAGE_W-1:0]   cart_inc;
  logic [WIN_BITS-1:0] win;
  logic [2:0]          src;
  logic [PAGE_W-1:0]   page;
  logic [7:0]          sel_n;

  assign io_wr  = ~iorq_n_i & ~wr_n_i & mreq_n_i & rfsh_n_i;
  assign hot_rd = ~mreq_n_i & rfsh_n_i & ~rd_n_i & (a_i[15:6] == 10'h3FF);

  // Only the first clock of a held strobe counts as an event.
  assign io_evt  = io_wr  & ~io_wr_q  & (state == ST_RUN);
  assign hot_evt = hot_rd & ~hot_rd_q & (state == ST_RUN);

  // MegaCart banking needs a power-of-two cart of at least 4 pages.
  assign cart_inc = cart_pages_i + PAGE_W'(1);
  assign megacart = ~sg1000_i & (cart_pages_i >= PAGE_W'(3)) &
                    ((cart_pages_i & cart_inc) == '0);

  assign win = a_i[15 -: WIN_BITS];

  // FSM: one INIT cycle after reset release, then RUN until reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= ST_INIT;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT) state_nxt = ST_RUN;
  end

  // Mapping registers and strobe history
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lower_mode    <= 2'b00;
      upper_mode    <= 2'b00;
      megacart_page <= '0;
      sgm_en        <= 1'b0;
      bank_idx      <= '0;
      ovr_en        <= '0;
      map_chg       <= 1'b0;
      io_wr_q       <= 1'b0;
      hot_rd_q      <= 1'b0;
      for (int i = 0; i < NWIN; i++) begin
        ovr_src[i]  <= 3'd0;
        ovr_page[i] <= '0;
      end
    end else begin
      io_wr_q  <= io_wr;
      hot_rd_q <= hot_rd;
      map_chg  <= 1'b0;
      if (state == ST_INIT) begin
        // Console boots BIOS + cart; ADAM boots writer + RAM.
        lower_mode <= adam_i ? 2'b00 : 2'b11;
        upper_mode <= adam_i ? 2'b00 : 2'b11;
      end else begin
        if (io_evt) begin
          if (a_i[7:0] == MODE_PORT) begin
            lower_mode <= d_i[1:0];
            upper_mode <= d_i[3:2];
            map_chg    <= 1'b1;
          end else if (a_i[7:0] == SGM_PORT) begin
            // The write still counts as an update attempt on ADAM.
            if (!adam_i) sgm_en <= d_i[0];
            map_chg <= 1'b1;
          end else if (a_i[7:0] == BANK_PORT) begin
            bank_idx <= d_i[WIN_BITS-1:0];
            map_chg  <= 1'b1;
          end else if (a_i[7:0] == BANK_DATA) begin
            ovr_en[bank_idx]   <= d_i[7];
            ovr_src[bank_idx]  <= d_i[6:4];
            ovr_page[bank_idx] <= PAGE_W'(d_i[3:0]);
            map_chg            <= 1'b1;
          end
        end
        if (hot_evt && megacart) begin
          megacart_page <= PAGE_W'(a_i[5:0]) & cart_pages_i;
          map_chg       <= 1'b1;
        end
      end
    end
  end

  // Combinational resolve of the current memory access
  always_comb begin
    src = SRC_NONE;
    page = '0;
    if (~mreq_n_i & rfsh_n_i & (state == ST_RUN)) begin
      if (ovr_en[win]) begin
        src  = ovr_src[win];
        page = ovr_page[win];
      end else if (sg1000_i) begin
        src = (a_i[15:14] == 2'b11) ? SRC_RAM : SRC_CART;
      end else if (!a_i[15]) begin
        case (lower_mode)
          2'b11: begin
            if (a_i[14:13] == 2'b00)      src = SRC_BIOS;
            else if (a_i[14:13] == 2'b11) src = SRC_RAM;
            else if (sgm_en)              src = SRC_RAM;   // SGM low RAM at 2000-5FFF
          end
          2'b10:   src = SRC_EXPRAM;
          2'b01:   src = SRC_RAM;
          default: src = SRC_WRITER;
        endcase
      end else begin
        case (upper_mode)
          2'b11: begin
            src = SRC_CART;
            if (megacart) page = a_i[14] ? megacart_page : cart_pages_i;
            else          page = PAGE_W'(a_i[14]);
          end
          2'b10:   src = SRC_EXPRAM;
          2'b01:   src = SRC_EXPROM;
          default: src = SRC_RAM;
        endcase
      end
    end
  end

  always_comb begin
    sel_n = 8'hFF;
    if (src != SRC_NONE) sel_n[src] = 1'b0;
  end

  assign src_o     = src;
  assign sel_n_o   = sel_n;
  assign page_o    = page;
  assign map_chg_o = map_chg;
  assign ready_o   = (state == ST_RUN);

endmodule
